mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
MIPS pipeline memory stage. Takes execute-stage results, performs loads and stores over a req/ack external memory port, and aligns and extends load data. Registers the me_* bundle consumed by the writeback stage, which selects between me_ExtMemRdData and me_ByData. Stalls upstream while an access is outstanding.

Parameters:
ADDR_W, 32, external byte-address width; ex_AluResult[ADDR_W-1:0] is the access address

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
ex_MemRead  in  1  load request
ex_MemWrite  in  1  store request; wins if both set
ex_MemSize  in  2  00 byte, 01 half, 10 word; 11 treated as word
ex_MemSigned  in  1  sign-extend byte/half loads
ex_AluResult  in  32  ALU result / effective address
ex_StoreData  in  32  store data, right-justified
ex_MemRegSel  in  1  writeback selects memory data
ex_RegWriteSel  in  1  writeback enable
ex_RegDest  in  5  destination register
ext_MemReq  out  1  access request, held until ack
ext_MemWe  out  1  1 = write
ext_MemAddr  out  ADDR_W  word-aligned address, low 2 bits 0
ext_MemBe  out  4  byte enables, bit n = byte lane n
ext_MemWrData  out  32  lane-replicated store data
ext_MemAck  in  1  access complete; read data valid this cycle
ext_MemRdData  in  32  raw read word
me_Stall  out  1  hold ex_* stable, do not advance
me_ExtMemRdData  out  32  aligned, extended load data
me_MemRegSel  out  1  registered ex_MemRegSel
me_RegWriteSel  out  1  registered writeback enable
me_RegDest  out  5  registered ex_RegDest
me_ByData  out  32  registered ex_AluResult

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. A reset in BUSY abandons the access; ext_MemReq is low after that edge.
- FSM states: IDLE and BUSY. me_Stall = (state==BUSY), Moore.
- IDLE, no memory op:
  - ex_* are registered into me_* at the edge (1-cycle latency).
  - ext_MemReq stays 0.
- IDLE, read or write:
  - At the edge, latch the request and go to BUSY.
  - The address, BE, data and control fields are registered and drive ext_Mem* from the next cycle.
  - me_RegWriteSel goes to 0 (bubble).
- BUSY:
  - ext_MemReq=1, all ext_Mem* held constant.
  - me_RegWriteSel held 0.
  - On ext_MemAck:
    - capture the aligned load data into me_ExtMemRdData;
    - load the latched me_MemRegSel, me_RegDest, me_ByData and me_RegWriteSel;
    - go to IDLE; ext_MemReq is low next cycle.
  - The instruction presented in the ack cycle is not consumed. It is consumed in the following IDLE cycle.
- Minimum memory-op latency: 2 edges (ack in first req cycle). me_RegWriteSel pulses 1 cycle per instruction.
- ext_MemAck outside BUSY is ignored.
- Lanes are little-endian (lane = addr[1:0]):
  - Byte: BE = 1<<addr[1:0].
  - Half: BE = addr[1] ? 1100 : 0011; addr[0] is ignored.
  - Word: BE = 1111; addr[1:0] are ignored.
- Store data: byte replicated ×4, half replicated ×2.
- Load data: selected lane shifted to bit 0, then zero- or sign-extended per ex_MemSigned. Word loads pass through.
- Stores: me_ExtMemRdData is 0 after ack; the other me_* fields pass as latched.

Optional Feature:
MEM_ALIGN_CHECK_EN.
- Defined:
  - adds output me_AlignErr (1 bit, reset 0);
  - a half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no external access and does not enter BUSY;
  - me_AlignErr pulses 1 for one cycle alongside the registered me_* (me_RegWriteSel forced 0).
- Undefined: no port; the low address bits are truncated as above.

Decomposition:
- Package mips_mem_pkg holds:
  - MEM_SIZE_BYTE/HALF/WORD encodings;
  - the IDLE/BUSY state encoding;
  - the lane-select helper constants.
- Sub-module mem_align: purely combinational. It generates BE and store-data replication, and performs load extract and extension. Instantiated once.

Test Plan:
- Reset held 2 cycles with ext_MemAck=1 -> all outputs 0; no req.
- LW addr 0x100, RegDest 5, ack 3 cycles after req with data 0xDEADBEEF -> ext_MemAddr 0x100, BE 1111, me_Stall high 4 cycles, then me_ExtMemRdData 0xDEADBEEF, me_RegDest 5, me_RegWriteSel 1-cycle pulse.
- Loads of word 0x8001_7F80:
  - LB signed addr 0x100 -> 0xFFFFFF80;
  - LBU addr 0x100 -> 0x00000080;
  - LH signed addr 0x102 -> 0xFFFF8001;
  - LHU -> 0x00008001.
- SB addr 0x101 data 0x000000AB -> ext_MemWe 1, BE 0010, ext_MemWrData 0xABABABAB; after ack me_RegWriteSel 0.
- Back-to-back ADD result 0x1234 (RegDest 3) then LW -> me_ByData 0x1234 next edge with no stall; the LW then stalls, and the following instruction is held until after ack.
- Reset asserted in BUSY, then ack 2 cycles later -> ext_MemReq 0 after reset edge; the late ack is ignored and me_* stay 0. With MEM_ALIGN_CHECK_EN, LW addr 0x102 -> no req, me_AlignErr one-cycle pulse.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared access-size encodings, FSM states and byte-lane constants for the memory stage.
package mips_mem_pkg;
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    // Size 11 is treated as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: req/ack external memory port between the memory stage (master) and memory (slave).
interface mem_stage_if #(parameter int ADDR_W = 32);
    logic              ext_MemReq;
    logic              ext_MemWe;
    logic [ADDR_W-1:0] ext_MemAddr;
    logic [3:0]        ext_MemBe;
    logic [31:0]       ext_MemWrData;
    logic              ext_MemAck;
    logic [31:0]       ext_MemRdData;
    modport master (output ext_MemReq, ext_MemWe, ext_MemAddr, ext_MemBe, ext_MemWrData,
                    input ext_MemAck, ext_MemRdData);
    modport slave (input ext_MemReq, ext_MemWe, ext_MemAddr, ext_MemBe, ext_MemWrData,
                   output ext_MemAck, ext_MemRdData);
endinterface

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane logic: store byte enables and replication, load extract and extension.
module mem_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_data_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_signed_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);
    logic [1:0]  ld_sel;
    logic [31:0] ld_shift;
    always_comb begin
        st_be_o   = is_word(st_size_i) ? BE_WORD :
                    st_size_i == MEM_SIZE_HALF ? (st_lane_i[1] ? BE_HALF_HI : BE_HALF_LO) :
                    BE_BYTE0 << st_lane_i;
        st_data_o = is_word(st_size_i) ? st_data_i :
                    st_size_i == MEM_SIZE_HALF ? {2{st_data_i[15:0]}} : {4{st_data_i[7:0]}};
        // Halves ignore addr[0]; words ignore both low bits.
        ld_sel    = is_word(ld_size_i) ? 2'b00 :
                    ld_size_i == MEM_SIZE_HALF ? {ld_lane_i[1], 1'b0} : ld_lane_i;
        ld_shift  = ld_word_i >> {ld_sel, 3'b000};
        ld_data_o = is_word(ld_size_i) ? ld_shift :
                    ld_size_i == MEM_SIZE_HALF ? {{16{ld_signed_i & ld_shift[15]}}, ld_shift[15:0]} :
                    {{24{ld_signed_i & ld_shift[7]}}, ld_shift[7:0]};
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage with req/ack memory port, stalling while an access is outstanding.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses and report them on me_AlignErr.
module mem_stage
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic [1:0]  ex_MemSize,
    input  logic        ex_MemSigned,
    input  logic [31:0] ex_AluResult,
    input  logic [31:0] ex_StoreData,
    input  logic        ex_MemRegSel,
    input  logic        ex_RegWriteSel,
    input  logic [4:0]  ex_RegDest,
    mem_stage_if.master ext,
    output logic        me_Stall,
    output logic [31:0] me_ExtMemRdData,
    output logic        me_MemRegSel,
    output logic        me_RegWriteSel,
    output logic [4:0]  me_RegDest,
    output logic [31:0] me_ByData
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        me_AlignErr
`endif
);
    state_t            state_q, state_d;
    logic              we_q, we_d, sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d, lane_q, lane_d;
    logic              p_regsel_q, p_regsel_d, p_rw_q, p_rw_d;
    logic [4:0]        p_dest_q, p_dest_d;
    logic [31:0]       p_by_q, p_by_d;
    logic [31:0]       rd_q, rd_d, by_q, by_d;
    logic              regsel_q, regsel_d, rw_q, rw_d;
    logic [4:0]        dest_q, dest_d;
    logic              mem_op, misalign;
    logic [3:0]        st_be;
    logic [31:0]       st_data, ld_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic              align_q, align_d;
    assign me_AlignErr = align_q;
`endif

    mem_align u_align (
        .st_size_i  (ex_MemSize),
        .st_lane_i  (ex_AluResult[1:0]),
        .st_data_i  (ex_StoreData),
        .ld_size_i  (size_q),
        .ld_signed_i(sgn_q),
        .ld_lane_i  (lane_q),
        .ld_word_i  (ext.ext_MemRdData),
        .st_be_o    (st_be),
        .st_data_o  (st_data),
        .ld_data_o  (ld_data)
    );

    assign mem_op             = ex_MemRead | ex_MemWrite;
    assign ext.ext_MemReq     = state_q == BUSY;
    assign ext.ext_MemWe      = we_q;
    assign ext.ext_MemAddr    = addr_q;
    assign ext.ext_MemBe      = be_q;
    assign ext.ext_MemWrData  = wdata_q;
    assign me_Stall           = state_q == BUSY;
    assign me_ExtMemRdData    = rd_q;
    assign me_MemRegSel       = regsel_q;
    assign me_RegWriteSel     = rw_q;
    assign me_RegDest         = dest_q;
    assign me_ByData          = by_q;

    always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
        misalign = (ex_MemSize == MEM_SIZE_HALF && ex_AluResult[0]) ||
                   (is_word(ex_MemSize) && ex_AluResult[1:0] != 2'b00);
        align_d  = 1'b0;
`else
        misalign = 1'b0;
`endif
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        lane_d     = lane_q;
        p_regsel_d = p_regsel_q;
        p_rw_d     = p_rw_q;
        p_dest_d   = p_dest_q;
        p_by_d     = p_by_q;
        rd_d       = rd_q;
        regsel_d   = regsel_q;
        dest_d     = dest_q;
        by_d       = by_q;
        rw_d       = 1'b0;
        if (state_q == IDLE) begin
            if (mem_op && !misalign) begin
                state_d    = BUSY;
                we_d       = ex_MemWrite;
                addr_d     = {ex_AluResult[ADDR_W-1:2], 2'b00};
                be_d       = st_be;
                wdata_d    = st_data;
                size_d     = ex_MemSize;
                sgn_d      = ex_MemSigned;
                lane_d     = ex_AluResult[1:0];
                p_regsel_d = ex_MemRegSel;
                p_rw_d     = ex_RegWriteSel;
                p_dest_d   = ex_RegDest;
                p_by_d     = ex_AluResult;
            end else begin
                regsel_d = ex_MemRegSel;
                dest_d   = ex_RegDest;
                by_d     = ex_AluResult;
                rw_d     = ex_RegWriteSel & ~misalign;
`ifdef MEM_ALIGN_CHECK_EN
                align_d  = misalign;
`endif
            end
        end else if (ext.ext_MemAck) begin
            state_d  = IDLE;
            rd_d     = we_q ? 32'h0 : ld_data;
            regsel_d = p_regsel_q;
            dest_d   = p_dest_q;
            by_d     = p_by_q;
            rw_d     = p_rw_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            lane_q     <= '0;
            p_regsel_q <= 1'b0;
            p_rw_q     <= 1'b0;
            p_dest_q   <= '0;
            p_by_q     <= '0;
            rd_q       <= '0;
            regsel_q   <= 1'b0;
            rw_q       <= 1'b0;
            dest_q     <= '0;
            by_q       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            align_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            lane_q     <= lane_d;
            p_regsel_q <= p_regsel_d;
            p_rw_q     <= p_rw_d;
            p_dest_q   <= p_dest_d;
            p_by_q     <= p_by_d;
            rd_q       <= rd_d;
            regsel_q   <= regsel_d;
            rw_q       <= rw_d;
            dest_q     <= dest_d;
            by_q       <= by_d;
`ifdef MEM_ALIGN_CHECK_EN
            align_q    <= align_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage; one task per scenario.
// Covers MEM_ALIGN_CHECK_EN behaviour when that macro is defined.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_MemRead, ex_MemWrite, ex_MemSigned, ex_MemRegSel, ex_RegWriteSel;
    logic [1:0]  ex_MemSize;
    logic [31:0] ex_AluResult, ex_StoreData;
    logic [4:0]  ex_RegDest;
    logic        me_Stall, me_MemRegSel, me_RegWriteSel;
    logic [31:0] me_ExtMemRdData, me_ByData;
    logic [4:0]  me_RegDest;
`ifdef MEM_ALIGN_CHECK_EN
    logic        me_AlignErr;
`endif
    int checks = 0;
    int errors = 0;

    mem_stage_if #(.ADDR_W(32)) ext ();

    mem_stage #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_MemRead     (ex_MemRead),
        .ex_MemWrite    (ex_MemWrite),
        .ex_MemSize     (ex_MemSize),
        .ex_MemSigned   (ex_MemSigned),
        .ex_AluResult   (ex_AluResult),
        .ex_StoreData   (ex_StoreData),
        .ex_MemRegSel   (ex_MemRegSel),
        .ex_RegWriteSel (ex_RegWriteSel),
        .ex_RegDest     (ex_RegDest),
        .ext            (ext),
        .me_Stall       (me_Stall),
        .me_ExtMemRdData(me_ExtMemRdData),
        .me_MemRegSel   (me_MemRegSel),
        .me_RegWriteSel (me_RegWriteSel),
        .me_RegDest     (me_RegDest),
        .me_ByData      (me_ByData)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .me_AlignErr    (me_AlignErr)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] alu, input logic [31:0] sd, input logic rs,
                          input logic rw, input logic [4:0] dst);
        ex_MemRead = rd; ex_MemWrite = wr; ex_MemSize = sz; ex_MemSigned = sg;
        ex_AluResult = alu; ex_StoreData = sd; ex_MemRegSel = rs; ex_RegWriteSel = rw; ex_RegDest = dst;
    endtask

    task automatic nop();
        set_ex(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        nop();
        ext.ext_MemAck = 1'b1;
        ext.ext_MemRdData = 32'hFFFF_FFFF;
        tick();
        tick();
        checks++; if (ext.ext_MemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ext.ext_MemReq); end
        checks++; if (me_Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", me_Stall); end
        checks++; if ({ext.ext_MemWe, ext.ext_MemBe, ext.ext_MemAddr, ext.ext_MemWrData} !== 69'h0) begin
            errors++; $display("FAIL reset_ext: we %b be %b addr %h wd %h want all 0", ext.ext_MemWe, ext.ext_MemBe, ext.ext_MemAddr, ext.ext_MemWrData); end
        checks++; if ({me_ExtMemRdData, me_MemRegSel, me_RegWriteSel, me_RegDest, me_ByData} !== 71'h0) begin
            errors++; $display("FAIL reset_me: rd %h rs %b rw %b dst %0d by %h want all 0", me_ExtMemRdData, me_MemRegSel, me_RegWriteSel, me_RegDest, me_ByData); end
        rst_n = 1'b1;
        ext.ext_MemAck = 1'b0;
        ext.ext_MemRdData = 32'h0;
    endtask

    task automatic test_lw();
        set_ex(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 5'd5);
        tick();
        nop();
        checks++; if (ext.ext_MemAddr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 00000100", ext.ext_MemAddr); end
        checks++; if (ext.ext_MemBe !== 4'b1111) begin errors++; $display("FAIL lw_be: got %b want 1111", ext.ext_MemBe); end
        checks++; if (ext.ext_MemWe !== 1'b0) begin errors++; $display("FAIL lw_we: got %b want 0", ext.ext_MemWe); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (me_Stall !== 1'b1 || ext.ext_MemReq !== 1'b1 || me_RegWriteSel !== 1'b0) begin
                errors++; $display("FAIL lw_busy%0d: stall %b req %b rw %b want 1 1 0", i, me_Stall, ext.ext_MemReq, me_RegWriteSel); end
            if (i == 3) begin ext.ext_MemAck = 1'b1; ext.ext_MemRdData = 32'hDEAD_BEEF; end
            tick();
        end
        ext.ext_MemAck = 1'b0;
        checks++; if (me_ExtMemRdData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", me_ExtMemRdData); end
        checks++; if (me_RegDest !== 5'd5 || me_RegWriteSel !== 1'b1 || me_MemRegSel !== 1'b1) begin
            errors++; $display("FAIL lw_wb: dst %0d rw %b rs %b want 5 1 1", me_RegDest, me_RegWriteSel, me_MemRegSel); end
        checks++; if (me_Stall !== 1'b0 || ext.ext_MemReq !== 1'b0) begin errors++; $display("FAIL lw_done: stall %b req %b want 0 0", me_Stall, ext.ext_MemReq); end
        tick();
        checks++; if (me_RegWriteSel !== 1'b0) begin errors++; $display("FAIL lw_pulse: rw %b want 0", me_RegWriteSel); end
    endtask

    task automatic test_load_ext();
        logic [31:0] addr [4] = '{32'h100, 32'h100, 32'h102, 32'h102};
        logic [1:0]  sz [4]   = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sg [4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  be [4]   = '{4'b0001, 4'b0001, 4'b1100, 4'b1100};
        logic [31:0] exp [4]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
        for (int i = 0; i < 4; i++) begin
            set_ex(1'b1, 1'b0, sz[i], sg[i], addr[i], 32'h0, 1'b1, 1'b1, 5'd8);
            tick();
            nop();
            checks++; if (ext.ext_MemBe !== be[i]) begin errors++; $display("FAIL ld%0d_be: got %b want %b", i, ext.ext_MemBe, be[i]); end
            ext.ext_MemAck = 1'b1;
            ext.ext_MemRdData = 32'h8001_7F80;
            tick();
            ext.ext_MemAck = 1'b0;
            checks++; if (me_ExtMemRdData !== exp[i]) begin errors++; $display("FAIL ld%0d_data: got %h want %h", i, me_ExtMemRdData, exp[i]); end
        end
        tick();
    endtask

    task automatic test_store();
        set_ex(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, 1'b0, 1'b0, 5'd0);
        tick();
        nop();
        checks++; if (ext.ext_MemWe !== 1'b1 || ext.ext_MemReq !== 1'b1) begin errors++; $display("FAIL sb_we: we %b req %b want 1 1", ext.ext_MemWe, ext.ext_MemReq); end
        checks++; if (ext.ext_MemBe !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b want 0010", ext.ext_MemBe); end
        checks++; if (ext.ext_MemWrData !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", ext.ext_MemWrData); end
        checks++; if (ext.ext_MemAddr !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h want 00000100", ext.ext_MemAddr); end
        ext.ext_MemAck = 1'b1;
        ext.ext_MemRdData = 32'h1234_5678;
        tick();
        ext.ext_MemAck = 1'b0;
        checks++; if (me_RegWriteSel !== 1'b0 || me_ExtMemRdData !== 32'h0) begin
            errors++; $display("FAIL sb_done: rw %b rd %h want 0 00000000", me_RegWriteSel, me_ExtMemRdData); end
        set_ex(1'b0, 1'b1, 2'b01, 1'b0, 32'h203, 32'h0000_BEEF, 1'b0, 1'b0, 5'd0);
        tick();
        nop();
        checks++; if (ext.ext_MemBe !== 4'b1100 || ext.ext_MemWrData !== 32'hBEEF_BEEF) begin
            errors++; $display("FAIL sh_lane: be %b wd %h want 1100 beefbeef", ext.ext_MemBe, ext.ext_MemWrData); end
        ext.ext_MemAck = 1'b1;
        tick();
        ext.ext_MemAck = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        set_ex(1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd3);
        tick();
        checks++; if (me_ByData !== 32'h1234 || me_RegDest !== 5'd3 || me_RegWriteSel !== 1'b1 || me_Stall !== 1'b0) begin
            errors++; $display("FAIL b2b_add: by %h dst %0d rw %b stall %b want 00001234 3 1 0", me_ByData, me_RegDest, me_RegWriteSel, me_Stall); end
        set_ex(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1, 5'd7);
        tick();
        checks++; if (me_Stall !== 1'b1 || me_RegWriteSel !== 1'b0) begin errors++; $display("FAIL b2b_lw_stall: stall %b rw %b want 1 0", me_Stall, me_RegWriteSel); end
        set_ex(1'b0, 1'b0, 2'b00, 1'b0, 32'h55, 32'h0, 1'b0, 1'b1, 5'd9);
        tick();
        checks++; if (me_Stall !== 1'b1 || me_ByData !== 32'h1234) begin errors++; $display("FAIL b2b_hold: stall %b by %h want 1 00001234", me_Stall, me_ByData); end
        ext.ext_MemAck = 1'b1;
        ext.ext_MemRdData = 32'h1122_3344;
        tick();
        ext.ext_MemAck = 1'b0;
        checks++; if (me_ExtMemRdData !== 32'h1122_3344 || me_ByData !== 32'h200 || me_RegDest !== 5'd7 || me_RegWriteSel !== 1'b1) begin
            errors++; $display("FAIL b2b_lw_done: rd %h by %h dst %0d rw %b want 11223344 00000200 7 1", me_ExtMemRdData, me_ByData, me_RegDest, me_RegWriteSel); end
        tick();
        nop();
        checks++; if (me_ByData !== 32'h55 || me_RegDest !== 5'd9 || me_RegWriteSel !== 1'b1 || me_Stall !== 1'b0) begin
            errors++; $display("FAIL b2b_next: by %h dst %0d rw %b stall %b want 00000055 9 1 0", me_ByData, me_RegDest, me_RegWriteSel, me_Stall); end
        tick();
    endtask

    task automatic test_reset_busy();
        set_ex(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b1, 1'b1, 5'd12);
        tick();
        nop();
        checks++; if (ext.ext_MemReq !== 1'b1) begin errors++; $display("FAIL rb_req: got %b want 1", ext.ext_MemReq); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (ext.ext_MemReq !== 1'b0 || me_Stall !== 1'b0) begin errors++; $display("FAIL rb_abandon: req %b stall %b want 0 0", ext.ext_MemReq, me_Stall); end
        tick();
        ext.ext_MemAck = 1'b1;
        ext.ext_MemRdData = 32'hCAFE_F00D;
        tick();
        ext.ext_MemAck = 1'b0;
        checks++; if ({me_ExtMemRdData, me_MemRegSel, me_RegWriteSel, me_RegDest, me_ByData} !== 71'h0 || ext.ext_MemReq !== 1'b0) begin
            errors++; $display("FAIL rb_late_ack: rd %h rs %b rw %b dst %0d by %h req %b want all 0", me_ExtMemRdData, me_MemRegSel, me_RegWriteSel, me_RegDest, me_ByData, ext.ext_MemReq); end
    endtask

    task automatic test_misaligned();
        set_ex(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, 1'b1, 5'd4);
        tick();
        nop();
`ifdef MEM_ALIGN_CHECK_EN
        checks++; if (ext.ext_MemReq !== 1'b0 || me_Stall !== 1'b0) begin errors++; $display("FAIL al_noreq: req %b stall %b want 0 0", ext.ext_MemReq, me_Stall); end
        checks++; if (me_AlignErr !== 1'b1 || me_RegWriteSel !== 1'b0 || me_ByData !== 32'h102) begin
            errors++; $display("FAIL al_err: err %b rw %b by %h want 1 0 00000102", me_AlignErr, me_RegWriteSel, me_ByData); end
        tick();
        checks++; if (me_AlignErr !== 1'b0) begin errors++; $display("FAIL al_pulse: err %b want 0", me_AlignErr); end
`else
        checks++; if (ext.ext_MemReq !== 1'b1 || ext.ext_MemAddr !== 32'h100 || ext.ext_MemBe !== 4'b1111) begin
            errors++; $display("FAIL trunc_addr: req %b addr %h be %b want 1 00000100 1111", ext.ext_MemReq, ext.ext_MemAddr, ext.ext_MemBe); end
        ext.ext_MemAck = 1'b1;
        ext.ext_MemRdData = 32'hA5A5_0F0F;
        tick();
        ext.ext_MemAck = 1'b0;
        checks++; if (me_ExtMemRdData !== 32'hA5A5_0F0F) begin errors++; $display("FAIL trunc_data: got %h want a5a50f0f", me_ExtMemRdData); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_back_to_back();
        test_misaligned();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
